// File: rtl/atm_light_scheduler_if.sv
// Publish channel from the atmospheric-light scheduler to the transmission/recovery stage.
// Handshake: a transfer occurs on a clk edge with atm_valid and atm_ready both high; the master holds data and atm_valid stable until then.
interface atm_light_scheduler_if #(
    parameter int DATA_W  = 8,
    parameter int RECIP_W = 16
);
    logic [DATA_W-1:0]  atm_r;
    logic [DATA_W-1:0]  atm_g;
    logic [DATA_W-1:0]  atm_b;
    logic [RECIP_W-1:0] inv_r;
    logic [RECIP_W-1:0] inv_g;
    logic [RECIP_W-1:0] inv_b;
    logic               atm_valid;
    logic               atm_ready;

    modport master (
        output atm_r, atm_g, atm_b, inv_r, inv_g, inv_b, atm_valid,
        input  atm_ready
    );

    modport slave (
        input  atm_r, atm_g, atm_b, inv_r, inv_g, inv_b, atm_valid,
        output atm_ready
    );
endinterface

// File: rtl/atm_light_scheduler.sv
// Tracks the brightest dark-channel pixel per frame, then walks one shared 1/x LUT over R, G, B
// and publishes A and 1/A atomically through the pub channel.
module atm_light_scheduler #(
    parameter int DATA_W  = 8,
    parameter int RECIP_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_valid,
    input  logic [DATA_W-1:0]     pix_r,
    input  logic [DATA_W-1:0]     pix_g,
    input  logic [DATA_W-1:0]     pix_b,
    input  logic [DATA_W-1:0]     pix_dark,
    input  logic                  pix_eof,
    output logic [DATA_W-1:0]     lut_in,
    input  logic [RECIP_W-1:0]    lut_out,
    output logic                  busy,
    output logic                  frame_drop,
    output logic [2:0]            dbg_state,
    atm_light_scheduler_if.master pub
);
    typedef enum logic [2:0] {
        ACCUM = 3'd0,
        LK_R  = 3'd1,
        LK_G  = 3'd2,
        LK_B  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    state_t             state_q;
    logic               first_q;
    logic [DATA_W-1:0]  cand_dark_q, cand_r_q, cand_g_q, cand_b_q;
    logic [DATA_W-1:0]  cand_dark_d, cand_r_d, cand_g_d, cand_b_d;
    logic [DATA_W-1:0]  snap_r_q, snap_g_q, snap_b_q;
    logic [RECIP_W-1:0] stage_inv_r_q, stage_inv_g_q;
    logic [DATA_W-1:0]  atm_r_q, atm_g_q, atm_b_q;
    logic [RECIP_W-1:0] inv_r_q, inv_g_q, inv_b_q;
    logic [DATA_W-1:0]  lut_in_q;
    logic               atm_valid_q, busy_q, frame_drop_q;
    logic               take_pix, eof_evt;

    // The LUT returns 0 at index 0, so a zero channel is looked up and published as 1.
    function automatic logic [DATA_W-1:0] clamp1(input logic [DATA_W-1:0] v);
        return (v == '0) ? ONE : v;
    endfunction

    always_comb begin
        eof_evt     = pix_valid && pix_eof;
        take_pix    = pix_valid && (first_q || (pix_dark > cand_dark_q));
        cand_dark_d = take_pix ? pix_dark : cand_dark_q;
        cand_r_d    = take_pix ? pix_r    : cand_r_q;
        cand_g_d    = take_pix ? pix_g    : cand_g_q;
        cand_b_d    = take_pix ? pix_b    : cand_b_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            first_q     <= 1'b1;
            cand_dark_q <= '0;
            cand_r_q    <= '0;
            cand_g_q    <= '0;
            cand_b_q    <= '0;
        end else if (pix_valid) begin
            cand_dark_q <= cand_dark_d;
            cand_r_q    <= cand_r_d;
            cand_g_q    <= cand_g_d;
            cand_b_q    <= cand_b_d;
            first_q     <= pix_eof;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ACCUM;
            snap_r_q      <= '0;
            snap_g_q      <= '0;
            snap_b_q      <= '0;
            stage_inv_r_q <= '0;
            stage_inv_g_q <= '0;
            atm_r_q       <= '0;
            atm_g_q       <= '0;
            atm_b_q       <= '0;
            inv_r_q       <= '0;
            inv_g_q       <= '0;
            inv_b_q       <= '0;
            lut_in_q      <= '0;
            atm_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_drop_q  <= 1'b0;
        end else begin
            frame_drop_q <= eof_evt && (state_q != ACCUM);
            case (state_q)
                ACCUM: begin
                    if (eof_evt) begin
                        snap_r_q <= clamp1(cand_r_d);
                        snap_g_q <= clamp1(cand_g_d);
                        snap_b_q <= clamp1(cand_b_d);
                        lut_in_q <= clamp1(cand_r_d);
                        busy_q   <= 1'b1;
                        state_q  <= LK_R;
                    end
                end
                LK_R: begin
                    stage_inv_r_q <= lut_out;
                    lut_in_q      <= snap_g_q;
                    state_q       <= LK_G;
                end
                LK_G: begin
                    stage_inv_g_q <= lut_out;
                    lut_in_q      <= snap_b_q;
                    state_q       <= LK_B;
                end
                LK_B: begin
                    // Blue reciprocal goes straight to the output so the whole set lands on one edge.
                    atm_r_q     <= snap_r_q;
                    atm_g_q     <= snap_g_q;
                    atm_b_q     <= snap_b_q;
                    inv_r_q     <= stage_inv_r_q;
                    inv_g_q     <= stage_inv_g_q;
                    inv_b_q     <= lut_out;
                    lut_in_q    <= '0;
                    atm_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (pub.atm_ready) begin
                        atm_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ACCUM;
                    end
                end
                default: begin
                    state_q <= ACCUM;
                end
            endcase
        end
    end

    assign lut_in        = lut_in_q;
    assign busy          = busy_q;
    assign frame_drop    = frame_drop_q;
    assign dbg_state     = state_q;
    assign pub.atm_r     = atm_r_q;
    assign pub.atm_g     = atm_g_q;
    assign pub.atm_b     = atm_b_q;
    assign pub.inv_r     = inv_r_q;
    assign pub.inv_g     = inv_g_q;
    assign pub.inv_b     = inv_b_q;
    assign pub.atm_valid = atm_valid_q;
endmodule

// File: tb/tb_atm_light_scheduler.sv
// Bench for atm_light_scheduler: directed scenarios plus randomized frames checked against a
// frame-level reference (max dark, earliest wins, clamp, rounded 1/x) and a publish scoreboard.
module tb_atm_light_scheduler;
  localparam int DATA_W  = 8;
  localparam int RECIP_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               pix_valid = 1'b0;
  logic [DATA_W-1:0]  pix_r = '0, pix_g = '0, pix_b = '0, pix_dark = '0;
  logic               pix_eof = 1'b0;
  logic [DATA_W-1:0]  lut_in;
  logic [RECIP_W-1:0] lut_out;
  logic               busy, frame_drop;
  logic [2:0]         dbg_state;
  logic               atm_ready = 1'b0;
  logic [71:0]        obs;

  atm_light_scheduler_if #(.DATA_W(DATA_W), .RECIP_W(RECIP_W)) pub_if ();

  atm_light_scheduler #(.DATA_W(DATA_W), .RECIP_W(RECIP_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_valid  (pix_valid),
    .pix_r      (pix_r),
    .pix_g      (pix_g),
    .pix_b      (pix_b),
    .pix_dark   (pix_dark),
    .pix_eof    (pix_eof),
    .lut_in     (lut_in),
    .lut_out    (lut_out),
    .busy       (busy),
    .frame_drop (frame_drop),
    .dbg_state  (dbg_state),
    .pub        (pub_if)
  );

  assign pub_if.atm_ready = atm_ready;
  assign obs = {pub_if.atm_r, pub_if.atm_g, pub_if.atm_b, pub_if.inv_r, pub_if.inv_g, pub_if.inv_b};

  // Reciprocal LUT: round(65536 / x), saturated to 16 bits, 0 at index 0.
  function automatic logic [15:0] ref_recip(input logic [7:0] x);
    int unsigned q;
    if (x == 8'd0) return 16'd0;
    q = (32'd65536 + 32'(x) / 32'd2) / 32'(x);
    if (q > 32'd65535) q = 32'd65535;
    return q[15:0];
  endfunction

  assign lut_out = ref_recip(lut_in);

  // ---------------- reference model / scoreboard state ----------------
  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;
  logic [103:0] exp_q[$];   // {eof edge, atm r/g/b, inv r/g/b}
  int          drop_q[$];   // edge index at which a drop is expected
  logic [31:0] frame_q[$];  // {dark, r, g, b} of the frame in progress
  bit          pending = 1'b0;
  logic [71:0] last_pub = '0;
  int          rise_count = 0;
  int          drop_count = 0;
  bit          prev_valid = 1'b0;
  bit          expect_low = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [103:0] make_entry(input int e0, input logic [7:0] r, input logic [7:0] g,
                                              input logic [7:0] b);
    logic [7:0] cr, cg, cb;
    cr = (r == 8'd0) ? 8'd1 : r;
    cg = (g == 8'd0) ? 8'd1 : g;
    cb = (b == 8'd0) ? 8'd1 : b;
    return {32'(e0), cr, cg, cb, ref_recip(cr), ref_recip(cg), ref_recip(cb)};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    drop_q.delete();
    frame_q.delete();
    pending  = 1'b0;
    last_pub = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    @(posedge clk); #1;
    pix_valid = 1'b0;
    pix_eof   = 1'b0;
  endtask

  task automatic drive_pix(input logic [7:0] d, input logic [7:0] r, input logic [7:0] g,
                           input logic [7:0] b, input bit eof);
    logic [31:0] best;
    @(posedge clk); #1;
    pix_valid = 1'b1;
    pix_dark  = d;
    pix_r     = r;
    pix_g     = g;
    pix_b     = b;
    pix_eof   = eof;
    frame_q.push_back({d, r, g, b});
    if (eof) begin
      best = frame_q[0];
      foreach (frame_q[i]) if (frame_q[i][31:24] > best[31:24]) best = frame_q[i];
      frame_q.delete();
      if (pending) drop_q.push_back(cyc + 1);
      else begin
        pending = 1'b1;
        exp_q.push_back(make_entry(cyc + 1, best[23:16], best[15:8], best[7:0]));
      end
    end
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (pub_if.atm_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [7:0] rand_ch();
    return ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [103:0] e;
    bit exp_drop;
    if (rst) begin
      prev_valid = 1'b0;
      expect_low = 1'b0;
    end else begin
      tests_run++;
      if (busy && !pub_if.atm_valid) begin
        if (lut_in === 8'd0) begin
          tests_failed++;
          $display("FAIL lut_in_lookup: lut_in=%0d during lookup, required nonzero", lut_in);
        end
      end else if (lut_in !== 8'd0) begin
        tests_failed++;
        $display("FAIL lut_in_idle: lut_in=%0d outside lookup, required 0", lut_in);
      end
      if (pub_if.atm_valid && !prev_valid) begin
        rise_count++;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL pub_unexpected: atm_valid rose at cycle %0d with no frame expected", cyc);
        end else begin
          e = exp_q[0];
          if (obs !== e[71:0] || cyc !== int'(e[103:72]) + 3) begin
            tests_failed++;
            $display("FAIL pub_data: got %h at cycle %0d, required %h at cycle %0d",
                     obs, cyc, e[71:0], int'(e[103:72]) + 3);
          end
          last_pub = e[71:0];
        end
      end
      if (!pub_if.atm_valid) begin
        tests_run++;
        if (obs !== last_pub) begin
          tests_failed++;
          $display("FAIL pub_hold: outputs %h, required held %h", obs, last_pub);
        end
      end
      if (expect_low) begin
        tests_run++;
        if (pub_if.atm_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL valid_after_accept: atm_valid=%b, required 0", pub_if.atm_valid);
        end
      end
      expect_low = pub_if.atm_valid && atm_ready;
      if (pub_if.atm_valid && atm_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        pending = 1'b0;
      end
      exp_drop = (drop_q.size() > 0) && (drop_q[0] == cyc);
      if (exp_drop) void'(drop_q.pop_front());
      if (frame_drop === 1'b1) drop_count++;
      tests_run++;
      if (frame_drop !== exp_drop) begin
        tests_failed++;
        $display("FAIL frame_drop: got %b at cycle %0d, required %b", frame_drop, cyc, exp_drop);
      end
      prev_valid = pub_if.atm_valid;
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    pix_valid = 1'b1;
    pix_dark  = 8'd99;
    pix_r     = 8'd10;
    pix_g     = 8'd20;
    pix_b     = 8'd30;
    pix_eof   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    pix_valid = 1'b0;
    pix_eof   = 1'b0;
    model_reset();
    @(negedge clk);
    tests_run++;
    if (obs !== 72'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h, required 0", obs);
    end
    tests_run++;
    if (pub_if.atm_valid !== 1'b0 || busy !== 1'b0 || frame_drop !== 1'b0 || lut_in !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: valid=%b busy=%b drop=%b lut_in=%0d, required all 0",
               pub_if.atm_valid, busy, frame_drop, lut_in);
    end
    repeat (4) begin
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0 || pub_if.atm_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_pixel_ignored: busy=%b valid=%b, required 0 0", busy, pub_if.atm_valid);
      end
    end
  endtask

  task automatic test_tie_frame();
    bit ok;
    int e0;
    idle();
    atm_ready = 1'b1;
    drive_pix(8'd10,  8'd9,   8'd9,   8'd9,   1'b0);
    drive_pix(8'd200, 8'd220, 8'd210, 8'd190, 1'b0);
    drive_pix(8'd200, 8'd1,   8'd1,   8'd1,   1'b0);
    drive_pix(8'd50,  8'd30,  8'd40,  8'd50,  1'b1);
    e0 = cyc + 1;
    idle();
    wait_valid(10, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL tie_timeout: atm_valid=0, required 1 within 10 cycles");
    end else begin
      tests_run++;
      if (obs !== {8'd220, 8'd210, 8'd190, 16'd298, 16'd312, 16'd345}) begin
        tests_failed++;
        $display("FAIL tie_data: got %h, required (220,210,190)/(298,312,345)", obs);
      end
      tests_run++;
      if (cyc !== e0 + 3) begin
        tests_failed++;
        $display("FAIL tie_latency: valid at cycle %0d, required %0d", cyc, e0 + 3);
      end
      @(negedge clk);
      tests_run++;
      if (pub_if.atm_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL tie_pulse: atm_valid=%b one cycle later, required 0", pub_if.atm_valid);
      end
    end
  endtask

  task automatic test_clamp();
    bit ok;
    idle();
    atm_ready = 1'b1;
    drive_pix(8'd5,   8'd9, 8'd9,   8'd9, 1'b0);
    drive_pix(8'd250, 8'd0, 8'd255, 8'd1, 1'b0);
    drive_pix(8'd100, 8'd3, 8'd3,   8'd3, 1'b1);
    idle();
    wait_valid(10, ok);
    tests_run++;
    if (!ok || obs !== {8'd1, 8'd255, 8'd1, 16'd65535, 16'd257, 16'd65535}) begin
      tests_failed++;
      $display("FAIL clamp_data: valid=%b got %h, required (1,255,1)/(65535,257,65535)", ok, obs);
    end
  endtask

  task automatic test_zero_dark();
    bit ok;
    idle();
    atm_ready = 1'b1;
    drive_pix(8'd0, 8'd5, 8'd6, 8'd7, 1'b0);
    drive_pix(8'd0, 8'd8, 8'd8, 8'd8, 1'b0);
    drive_pix(8'd0, 8'd9, 8'd9, 8'd9, 1'b1);
    idle();
    wait_valid(10, ok);
    tests_run++;
    if (!ok || obs !== {8'd5, 8'd6, 8'd7, 16'd13107, 16'd10923, 16'd9362}) begin
      tests_failed++;
      $display("FAIL zero_dark_data: valid=%b got %h, required (5,6,7)/(13107,10923,9362)", ok, obs);
    end
  endtask

  task automatic test_drop();
    bit ok;
    logic [71:0] f1;
    f1 = {8'd100, 8'd50, 8'd25, 16'd655, 16'd1311, 16'd2621};
    idle();
    atm_ready = 1'b0;
    drive_pix(8'd20, 8'd1,   8'd2,  8'd3,  1'b0);
    drive_pix(8'd80, 8'd100, 8'd50, 8'd25, 1'b0);
    drive_pix(8'd40, 8'd7,   8'd7,  8'd7,  1'b1);
    idle();
    wait_valid(10, ok);
    tests_run++;
    if (!ok || obs !== f1) begin
      tests_failed++;
      $display("FAIL drop_frame1: valid=%b got %h, required %h", ok, obs, f1);
    end
    drive_pix(8'd30, 8'd11, 8'd12, 8'd13, 1'b0);
    drive_pix(8'd90, 8'd44, 8'd45, 8'd46, 1'b0);
    drive_pix(8'd60, 8'd21, 8'd22, 8'd23, 1'b1);
    idle();
    @(negedge clk);
    tests_run++;
    if (frame_drop !== 1'b1 || pub_if.atm_valid !== 1'b1 || obs !== f1) begin
      tests_failed++;
      $display("FAIL drop_pulse: drop=%b valid=%b out=%h, required 1 1 %h",
               frame_drop, pub_if.atm_valid, obs, f1);
    end
    idle();
    @(negedge clk);
    tests_run++;
    if (frame_drop !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_single: frame_drop=%b second cycle, required 0", frame_drop);
    end
    repeat (14) idle();
    @(negedge clk);
    tests_run++;
    if (pub_if.atm_valid !== 1'b1 || obs !== f1) begin
      tests_failed++;
      $display("FAIL drop_hold: valid=%b out=%h, required 1 %h", pub_if.atm_valid, obs, f1);
    end
    idle();
    atm_ready = 1'b1;
    repeat (2) idle();
    @(negedge clk);
    tests_run++;
    if (pub_if.atm_valid !== 1'b0 || obs !== f1) begin
      tests_failed++;
      $display("FAIL drop_accept: valid=%b out=%h, required 0 %h", pub_if.atm_valid, obs, f1);
    end
    drive_pix(8'd10, 8'd5,  8'd5,  8'd5,  1'b0);
    drive_pix(8'd90, 8'd60, 8'd70, 8'd80, 1'b0);
    drive_pix(8'd90, 8'd9,  8'd9,  8'd9,  1'b1);
    idle();
    wait_valid(10, ok);
    tests_run++;
    if (!ok || obs !== {8'd60, 8'd70, 8'd80, 16'd1092, 16'd936, 16'd819}) begin
      tests_failed++;
      $display("FAIL drop_frame3: valid=%b got %h, required (60,70,80)/(1092,936,819)", ok, obs);
    end
  endtask

  task automatic test_reset_mid_lk();
    bit ok;
    idle();
    atm_ready = 1'b1;
    repeat (3) idle();
    drive_pix(8'd40, 8'd11,  8'd12,  8'd13,  1'b0);
    drive_pix(8'd70, 8'd150, 8'd160, 8'd170, 1'b0);
    drive_pix(8'd70, 8'd1,   8'd1,   8'd1,   1'b1);
    idle();
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_lk_busy: busy=%b after eof, required 1", busy);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (obs !== 72'd0 || busy !== 1'b0 || pub_if.atm_valid !== 1'b0 || lut_in !== 8'd0) begin
      tests_failed++;
      $display("FAIL rst_lk_clear: out=%h busy=%b valid=%b lut_in=%0d, required all 0",
               obs, busy, pub_if.atm_valid, lut_in);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests_run++;
      if (pub_if.atm_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL rst_lk_discard: atm_valid=%b after reset, required 0", pub_if.atm_valid);
      end
    end
    drive_pix(8'd5, 8'd40, 8'd50, 8'd60,  1'b0);
    drive_pix(8'd9, 8'd80, 8'd90, 8'd100, 1'b1);
    idle();
    wait_valid(10, ok);
    tests_run++;
    if (!ok || obs !== {8'd80, 8'd90, 8'd100, 16'd819, 16'd728, 16'd655}) begin
      tests_failed++;
      $display("FAIL rst_lk_next: valid=%b got %h, required (80,90,100)/(819,728,655)", ok, obs);
    end
  endtask

  task automatic test_back_to_back();
    int r0, d0;
    idle();
    atm_ready = 1'b1;
    repeat (3) idle();
    r0 = rise_count;
    d0 = drop_count;
    for (int f = 0; f < 6; f++) begin
      for (int p = 0; p < 4; p++)
        drive_pix(8'($urandom_range(0, 255)), rand_ch(), rand_ch(), rand_ch(), p == 3);
      idle();
    end
    repeat (6) idle();
    @(negedge clk);
    tests_run++;
    if (rise_count !== r0 + 6) begin
      tests_failed++;
      $display("FAIL b2b_publishes: %0d publishes, required 6", rise_count - r0);
    end
    tests_run++;
    if (drop_count !== d0) begin
      tests_failed++;
      $display("FAIL b2b_drops: %0d drops, required 0", drop_count - d0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0)
        drive_pix(8'($urandom_range(0, 15)), rand_ch(), rand_ch(), rand_ch(),
                  $urandom_range(0, 5) == 0);
      else
        idle();
      atm_ready = ($urandom_range(0, 1) == 1);
    end
    idle();
    atm_ready = 1'b1;
    repeat (12) idle();
    @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0 || drop_q.size() != 0) begin
      tests_failed++;
      $display("FAIL random_drain: %0d publishes and %0d drops outstanding, required 0 0",
               exp_q.size(), drop_q.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running at 1000000 ns, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_tie_frame();
    test_clamp();
    test_zero_dark();
    test_drop();
    test_reset_mid_lk();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/atm_light_scheduler.md
# atm_light_scheduler

Per-frame atmospheric-light controller for the dehazing pipeline. It tracks the brightest dark-channel pixel of each frame and latches that pixel's RGB as the atmospheric light A. At end of frame it sequences one shared 1/x reciprocal LUT (8-bit in, Q0.16 out, combinational) across the three channels. It then publishes A and 1/A to the transmission/recovery stage through a valid/ready handshake.

## Interface
- DATA_W, 8, pixel and LUT index width
- RECIP_W, 16, reciprocal width (Q0.16)

- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- pix_valid  in  1  pixel strobe
- pix_r, pix_g, pix_b  in  DATA_W each  pixel colour
- pix_dark  in  DATA_W  dark-channel value of the same pixel
- pix_eof  in  1  last pixel of frame; qualified by pix_valid
- lut_in  out  DATA_W  index to the shared reciprocal LUT
- lut_out  in  RECIP_W  LUT result, valid in the same cycle as lut_in
- atm_r, atm_g, atm_b  out  DATA_W each  published A (clamped)
- inv_r, inv_g, inv_b  out  RECIP_W each  published 1/A
- atm_valid  out  1  published set available
- atm_ready  in  1  consumer accepts
- busy  out  1  sequencer not in ACCUM
- frame_drop  out  1  one-cycle pulse when a frame result is discarded

## Operation
- Accumulator runs every cycle, independent of sequencer state.
  - On pix_valid, the pixel is captured into cand_{dark,r,g,b} when it is the first valid pixel of the frame, or when pix_dark > cand_dark (strictly greater).
  - On a tie, the earliest pixel wins.
  - An all-zero dark frame captures its first pixel.
- Pixel with pix_eof asserted:
  - The pixel is evaluated first; it can be the winner.
  - The resulting candidate is copied to the snapshot, and the accumulator re-arms (first-pixel flag set).
  - If the sequencer is in ACCUM, it moves to LK_R.
  - Otherwise the snapshot is not taken, frame_drop pulses, and the published outputs are untouched.
- Clamp: each snapshot channel is forced to 1 if it is 0. The LUT returns 0 at index 0. The clamped value is what is looked up and what is published.
- States and transitions:
  - ACCUM → LK_R on the eof edge.
  - LK_R: lut_in = snap_r; the edge stores lut_out → stage_inv_r; → LK_G.
  - LK_G: same pattern for G; → LK_B.
  - LK_B: same pattern for B; → HOLD. The HOLD-entry edge copies snapshot and stage values to all published outputs atomically.
  - HOLD: atm_valid = 1. On atm_valid & atm_ready → ACCUM.
- lut_in = 0 outside the LK states.
- busy = (state != ACCUM).
- Published outputs change only on HOLD entry. They keep their values after the handshake until the next publish.
- Pixels arriving during LK/HOLD go into the next frame's accumulation.
- Width rules: comparisons are unsigned, DATA_W bits. No arithmetic is done on the reciprocals; they are pass-through from the LUT.

## Timing
- Reset (sync, at the clk edge with rst = 1):
  - state = ACCUM; cand, snapshot and stage cleared; first-pixel flag set.
  - All atm_*, inv_*, lut_in = 0; atm_valid = 0, busy = 0, frame_drop = 0.
  - A pixel presented in the reset cycle is ignored.
  - A reset mid-LK or mid-HOLD discards that frame.
- Latency: eof sampled at edge E0 → LK_R in E0–E1, LK_G in E1–E2, LK_B in E2–E3 → atm_valid = 1 from edge E3 (3 cycles).
- Handshake:
  - atm_valid stays high until sampled with atm_ready.
  - atm_valid goes low the cycle after acceptance.
  - If atm_ready is already high at HOLD entry, atm_valid lasts exactly 1 cycle.
  - atm_ready is ignored while atm_valid = 0.
- The earliest next eof that can be accepted arrives in the cycle after acceptance, when state = ACCUM.
- frame_drop is registered and high for exactly one cycle per dropped eof.

## Test plan
- Frame of 4 pixels, dark = 10, 200, 200, 50; pixel 2 RGB = (220, 210, 190), pixel 3 RGB = (1, 1, 1) → atm = (220, 210, 190), inv = (298, 312, 345); atm_valid rises 3 cycles after the eof edge; the tie keeps pixel 2.
- Winner RGB = (0, 255, 1) → atm = (1, 255, 1), inv = (65535, 257, 65535); lut_in never 0 during LK states.
- Frame with every pix_dark = 0, first pixel RGB = (5, 6, 7) → atm = (5, 6, 7), inv = (13107, 10923, 9362).
- atm_ready held low for 20 cycles while a second 3-pixel frame ends → frame_drop single pulse; outputs keep frame-1 values; after acceptance, a third frame publishes normally.
- rst asserted in LK_G → next cycle all outputs 0, busy = 0, atm_valid never rises for that frame; the following frame publishes correctly.
- atm_ready tied high, back-to-back frames of 4 pixels each → each frame gets exactly one 1-cycle atm_valid; frame_drop is never asserted.
